// File: rtl/add_multicycle.sv
// Multi-cycle signed adder. Each cycle adds one CHUNK_WIDTH slice, LSB slice first, and keeps the ripple carry in a register.
// The result is (ARG_WIDTH+1) bits wide and full precision, and an overflow flag comes with it.
module add_multicycle #(
    parameter int ARG_WIDTH   = 32,
    parameter int CHUNK_WIDTH = 8,
    parameter int RES_WIDTH   = ARG_WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arg_vld,
    output logic                 arg_rdy,
    input  logic [ARG_WIDTH-1:0] a,
    input  logic [ARG_WIDTH-1:0] b,
    output logic                 res_vld,
    input  logic                 res_rdy,
    output logic [RES_WIDTH-1:0] res,
    output logic                 overflow
);

    localparam int N     = ARG_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state, state_nxt;
    logic [ARG_WIDTH-1:0]   a_q, b_q;
    logic [ARG_WIDTH:0]     res_q;
    logic                   ovf_q;
    logic                   carry_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CHUNK_WIDTH-1:0] a_chunk, b_chunk;
    logic [CHUNK_WIDTH:0]   chunk_sum;
    logic                   top_msb;
    logic                   last_chunk;

    // Handshakes: a transfer happens on a rising edge where valid && ready. The producer holds
    // its valid/data until it sees ready. arg_rdy is high only in IDLE and res_vld only in DONE,
    // so the result handshake and the next operand handshake never fall in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        arg_rdy   = 1'b0;
        res_vld   = 1'b0;
        case (state)
            IDLE: begin
                arg_rdy = 1'b1;
                if (arg_vld) state_nxt = CALC;
            end
            CALC: begin
                if (last_chunk) state_nxt = DONE;
            end
            DONE: begin
                res_vld = 1'b1;
                if (res_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign last_chunk = (cnt_q == LAST_CHUNK);
    assign a_chunk    = a_q[int'(cnt_q) * CHUNK_WIDTH +: CHUNK_WIDTH];
    assign b_chunk    = b_q[int'(cnt_q) * CHUNK_WIDTH +: CHUNK_WIDTH];
    assign chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK_WIDTH{1'b0}}, carry_q};
    // The extra result bit is the sign extension of both operands plus the final carry.
    assign top_msb    = a_q[ARG_WIDTH-1] ^ b_q[ARG_WIDTH-1] ^ chunk_sum[CHUNK_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arg_vld) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                CALC: begin
                    res_q[int'(cnt_q) * CHUNK_WIDTH +: CHUNK_WIDTH] <= chunk_sum[CHUNK_WIDTH-1:0];
                    carry_q <= chunk_sum[CHUNK_WIDTH];
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_chunk) begin
                        res_q[ARG_WIDTH] <= top_msb;
                        ovf_q            <= top_msb ^ chunk_sum[CHUNK_WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign res      = res_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_add_multicycle.sv
// Directed testbench for add_multicycle (ARG_WIDTH=32, CHUNK_WIDTH=8). Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_add_multicycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        arg_vld;
    logic        arg_rdy;
    logic [31:0] a, b;
    logic        res_vld;
    logic        res_rdy;
    logic [32:0] res;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    add_multicycle #(.ARG_WIDTH(32), .CHUNK_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(arg_rdy), .a(a), .b(b),
        .res_vld(res_vld), .res_rdy(res_rdy), .res(res), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present operands for one edge, then scramble them so only the accept edge matters.
    task automatic drive_accept(input logic [31:0] av, input logic [31:0] bv);
        arg_vld = 1'b1;
        a = av;
        b = bv;
        @(posedge clk); #1;
        arg_vld = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // Returns the number of edges after the accept until res_vld is seen, or -1 on timeout.
    task automatic wait_res(output int n);
        n = 0;
        while (!res_vld && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!res_vld) n = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; arg_vld = 1'b0; res_rdy = 1'b1; a = '0; b = '0;
        #1;
        checks++; if (arg_rdy !== 1'b1) begin errors++; $display("FAIL reset_arg_rdy: got %b expected 1", arg_rdy); end
        checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL reset_res_vld: got %b expected 0", res_vld); end
        checks++; if (res !== 33'h0) begin errors++; $display("FAIL reset_res: got %h expected 0", res); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (arg_rdy !== 1'b1) begin errors++; $display("FAIL reset_idle_rdy: got %b expected 1", arg_rdy); end
    endtask

    task automatic test_basic();
        int n;
        res_rdy = 1'b1;
        drive_accept(32'd5, 32'd7);
        wait_res(n);
        checks++; if (n !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", n); end
        checks++; if (res !== 33'h0_0000_000C) begin errors++; $display("FAIL basic_res: got %h expected 00000000c", res); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow: got %b expected 0", overflow); end
        checks++; if (arg_rdy !== 1'b0) begin errors++; $display("FAIL basic_rdy_in_done: got %b expected 0", arg_rdy); end
        // The handshake edge returns to IDLE, so arg_rdy is already high one edge after res_vld rose.
        @(posedge clk); #1;
        checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL basic_vld_drop: got %b expected 0", res_vld); end
        checks++; if (arg_rdy !== 1'b1) begin errors++; $display("FAIL basic_rdy_back: got %b expected 1", arg_rdy); end
        checks++; if (res !== 33'h0_0000_000C) begin errors++; $display("FAIL basic_res_held: got %h expected 00000000c", res); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta[2];
        logic [31:0] tb_v[2];
        logic [32:0] te[2];
        int          t_acc[2];
        int          n;
        ta[0] = 32'h1234_5678; tb_v[0] = 32'h0F0F_0F0F; te[0] = 33'h0_2143_6587;
        ta[1] = 32'hFFFF_FFFF; tb_v[1] = 32'hFFFF_FFFF; te[1] = 33'h1_FFFF_FFFE;
        res_rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_accept(ta[i], tb_v[i]);
            t_acc[i] = cyc;
            wait_res(n);
            checks++; if (n !== 4) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected 4", i, n); end
            checks++; if (res !== te[i]) begin errors++; $display("FAIL b2b_res[%0d]: got %h expected %h", i, res, te[i]); end
            checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow[%0d]: got %b expected 0", i, overflow); end
            @(posedge clk); #1;
        end
        checks++; if (t_acc[1] - t_acc[0] !== 6) begin errors++; $display("FAIL b2b_interval: got %0d expected 6", t_acc[1] - t_acc[0]); end
    endtask

    task automatic test_backpressure();
        int n;
        res_rdy = 1'b0;
        drive_accept(32'd100, 32'hFFFF_FED4);
        wait_res(n);
        checks++; if (n !== 4) begin errors++; $display("FAIL bp_latency: got %0d expected 4", n); end
        arg_vld = 1'b1; a = 32'd1; b = 32'd1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (res_vld !== 1'b1) begin errors++; $display("FAIL bp_vld[%0d]: got %b expected 1", i, res_vld); end
            checks++; if (arg_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy[%0d]: got %b expected 0", i, arg_rdy); end
            checks++; if (res !== 33'h1_FFFF_FF38) begin errors++; $display("FAIL bp_res[%0d]: got %h expected 1ffffff38", i, res); end
            checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow[%0d]: got %b expected 0", i, overflow); end
            @(posedge clk); #1;
        end
        res_rdy = 1'b1;
        @(posedge clk); #1;
        checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL bp_release_vld: got %b expected 0", res_vld); end
        checks++; if (arg_rdy !== 1'b1) begin errors++; $display("FAIL bp_release_rdy: got %b expected 1", arg_rdy); end
        @(posedge clk); #1;
        arg_vld = 1'b0; a = $urandom; b = $urandom;
        checks++; if (arg_rdy !== 1'b0) begin errors++; $display("FAIL bp_second_accept: got %b expected 0", arg_rdy); end
        wait_res(n);
        checks++; if (n !== 4) begin errors++; $display("FAIL bp_second_latency: got %0d expected 4", n); end
        checks++; if (res !== 33'h0_0000_0002) begin errors++; $display("FAIL bp_second_res: got %h expected 000000002", res); end
        @(posedge clk); #1;
    endtask

    task automatic test_carry_chain();
        logic [31:0] ta[3];
        logic [31:0] tb_v[3];
        logic [32:0] te[3];
        int          n;
        ta[0] = 32'hFFFF_FFFF; tb_v[0] = 32'd1; te[0] = 33'h0_0000_0000;
        ta[1] = 32'h0000_00FF; tb_v[1] = 32'd1; te[1] = 33'h0_0000_0100;
        ta[2] = 32'h00FF_FFFF; tb_v[2] = 32'd1; te[2] = 33'h0_0100_0000;
        res_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_accept(ta[i], tb_v[i]);
            wait_res(n);
            checks++; if (n !== 4) begin errors++; $display("FAIL carry_latency[%0d]: got %0d expected 4", i, n); end
            checks++; if (res !== te[i]) begin errors++; $display("FAIL carry_res[%0d]: got %h expected %h", i, res, te[i]); end
            checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL carry_overflow[%0d]: got %b expected 0", i, overflow); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_overflow();
        logic [31:0] ta[4];
        logic [31:0] tb_v[4];
        logic [32:0] te[4];
        logic        tov[4];
        int          n;
        ta[0] = 32'h7FFF_FFFF; tb_v[0] = 32'd1;         te[0] = 33'h0_8000_0000; tov[0] = 1'b1;
        ta[1] = 32'h8000_0000; tb_v[1] = 32'h8000_0000; te[1] = 33'h1_0000_0000; tov[1] = 1'b1;
        ta[2] = 32'h7FFF_FFFF; tb_v[2] = 32'h7FFF_FFFF; te[2] = 33'h0_FFFF_FFFE; tov[2] = 1'b1;
        ta[3] = 32'h8000_0000; tb_v[3] = 32'h7FFF_FFFF; te[3] = 33'h1_FFFF_FFFF; tov[3] = 1'b0;
        res_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_accept(ta[i], tb_v[i]);
            wait_res(n);
            checks++; if (n !== 4) begin errors++; $display("FAIL ovf_latency[%0d]: got %0d expected 4", i, n); end
            checks++; if (res !== te[i]) begin errors++; $display("FAIL ovf_res[%0d]: got %h expected %h", i, res, te[i]); end
            checks++; if (overflow !== tov[i]) begin errors++; $display("FAIL ovf_flag[%0d]: got %b expected %b", i, overflow, tov[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_calc();
        int n;
        res_rdy = 1'b1;
        drive_accept(32'h0000_00FF, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL midrst_vld: got %b expected 0", res_vld); end
        checks++; if (res !== 33'h0) begin errors++; $display("FAIL midrst_res: got %h expected 0", res); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow: got %b expected 0", overflow); end
        checks++; if (arg_rdy !== 1'b1) begin errors++; $display("FAIL midrst_rdy: got %b expected 1", arg_rdy); end
        @(posedge clk); #1;
        checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL midrst_held_vld: got %b expected 0", res_vld); end
        rst = 1'b0;
        @(posedge clk); #1;
        drive_accept(32'd3, 32'd4);
        wait_res(n);
        checks++; if (n !== 4) begin errors++; $display("FAIL midrst_latency: got %0d expected 4", n); end
        checks++; if (res !== 33'h0_0000_0007) begin errors++; $display("FAIL midrst_res_after: got %h expected 000000007", res); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf_after: got %b expected 0", overflow); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_carry_chain();
        test_overflow();
        test_reset_mid_calc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
